// File: rtl/parity_serial_tx.sv
// parity_serial_tx
//   Serialises a data word and its parity bit into a framed, LSB-first bit
//   stream:
//     start(0), DATA_WIDTH data bits, parity bit, STOP_BITS stop bits(1).
//   Each bit is held for CLKS_PER_BIT clock cycles. The line idles high.
//
// Optional feature:
//   `define PARITY_SELF_CHECK_EN
//     Adds the parityErr output. On accept, parityInput is compared against
//     (^dataInput)^ODD_PARITY. The flag is sticky until the next accept or
//     reset. The transmitted parity bit is always parityInput, unmodified.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   dataInput    in   [DATA_WIDTH-1:0] word to transmit
//   parityInput  in   parity bit for dataInput, sent unmodified
//   inValid      in   dataInput/parityInput valid
//   inReady      out  a word can be accepted this cycle (state is IDLE)
//   serialOut    out  framed serial stream, idles high
//   busy         out  frame in progress
//   frameDone    out  1-cycle pulse on the last cycle of the final stop bit
//   parityErr    out  parity self-check flag (PARITY_SELF_CHECK_EN only)
module parity_serial_tx #(
  parameter int DATA_WIDTH   = 64,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int ODD_PARITY   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataInput,
  input  logic                  parityInput,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  serialOut,
  output logic                  busy,
  output logic                  frameDone
`ifdef PARITY_SELF_CHECK_EN
  ,
  output logic                  parityErr
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_WIDTH < 1 || CLKS_PER_BIT < 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("parity_serial_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q,  state_d;
  logic [CNT_W-1:0]        clkcnt_q, clkcnt_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]   shift_q,  shift_d;
  logic                    par_q,    par_d;

  logic                    serial_q, serial_d;
  logic                    ready_q,  ready_d;
  logic                    busy_q,   busy_d;
  logic                    done_q,   done_d;

`ifdef PARITY_SELF_CHECK_EN
  localparam logic ODD_BIT = (ODD_PARITY != 0);
  logic                    err_q,    err_d;
`endif

  logic                    advance;

  assign advance = (clkcnt_q == CLK_LAST);

  // Next-state logic. bitcnt_q counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d  = state_q;
    clkcnt_d = clkcnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
`ifdef PARITY_SELF_CHECK_EN
    err_d    = err_q;
`endif

    if (state_q == S_IDLE) begin
      if (inValid) begin
        state_d  = S_START;
        clkcnt_d = '0;
        bitcnt_d = '0;
        shift_d  = dataInput;
        par_d    = parityInput;
`ifdef PARITY_SELF_CHECK_EN
        err_d    = (parityInput != ((^dataInput) ^ ODD_BIT));
`endif
      end
    end else begin
      clkcnt_d = advance ? '0 : clkcnt_q + 1'b1;
      if (advance) begin
        case (state_q)
          S_START: begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (bitcnt_q == DATA_LAST) begin
              state_d  = S_PARITY;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            state_d  = S_STOP;
            bitcnt_d = '0;
          end
          S_STOP: begin
            if (bitcnt_q == STOP_LAST) begin
              state_d  = S_IDLE;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state it belongs to in the same cycle with no path from inputs.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (clkcnt_d == CLK_LAST) &&
              (bitcnt_d == STOP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      clkcnt_q <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARITY_SELF_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      clkcnt_q <= clkcnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PARITY_SELF_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign serialOut = serial_q;
  assign inReady   = ready_q;
  assign busy      = busy_q;
  assign frameDone = done_q;
`ifdef PARITY_SELF_CHECK_EN
  assign parityErr = err_q;
`endif

endmodule

// File: tb/tb_parity_serial_tx.sv
module tb_parity_serial_tx;

  localparam int DW    = 64;
  localparam int CPB   = 4;
  localparam int STOPB = 1;
  localparam int ODD   = 0;
  localparam int NBITS = 2 + DW + STOPB;
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] dataInput;
  logic          parityInput;
  logic          inValid;
  logic          inReady;
  logic          serialOut;
  logic          busy;
  logic          frameDone;
`ifdef PARITY_SELF_CHECK_EN
  logic          parityErr;
`endif

  int n_total = 0;
  int n_pass  = 0;

  parity_serial_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOPB),
    .ODD_PARITY  (ODD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dataInput  (dataInput),
    .parityInput(parityInput),
    .inValid    (inValid),
    .inReady    (inReady),
    .serialOut  (serialOut),
    .busy       (busy),
    .frameDone  (frameDone)
`ifdef PARITY_SELF_CHECK_EN
    ,
    .parityErr  (parityErr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".serialOut"}, 64'(serialOut), 64'd1);
    check({tag, ".inReady"},   64'(inReady),   64'd1);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".frameDone"}, 64'(frameDone), 64'd0);
  endtask

  function automatic logic exp_err(input logic [DW-1:0] d, input logic p);
    // Count ones with plain arithmetic; the correct parity makes the total
    // (plus the odd-parity offset) even.
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return ((ones + int'(p) + ODD) % 2) != 0;
  endfunction

  // Called at the sample point right after the accepting edge. Checks every
  // cycle of the frame plus the following idle cycle.
  task automatic check_frame(input string tag, input logic [DW-1:0] d, input logic p);
    logic [NBITS-1:0] f;
    logic             e;
    f = {{STOPB{1'b1}}, p, d, 1'b0};
    e = exp_err(d, p);
    for (int k = 0; k < FRAME; k++) begin
      check({tag, ".serial"},    64'(serialOut), 64'(f[k / CPB]));
      check({tag, ".busy"},      64'(busy),      64'd1);
      check({tag, ".inReady"},   64'(inReady),   64'd0);
      check({tag, ".frameDone"}, 64'(frameDone), 64'(k == FRAME - 1));
`ifdef PARITY_SELF_CHECK_EN
      check({tag, ".parityErr"}, 64'(parityErr), 64'(e));
`endif
      tick();
    end
    check_idle({tag, ".after"});
`ifdef PARITY_SELF_CHECK_EN
    check({tag, ".errSticky"}, 64'(parityErr), 64'(e));
`else
    if (e) begin end
`endif
  endtask

  task automatic send(input string tag, input logic [DW-1:0] d, input logic p);
    dataInput   = d;
    parityInput = p;
    inValid     = 1'b1;
    tick();
    inValid     = 1'b0;
    dataInput   = {$urandom, $urandom};
    parityInput = 1'($urandom);
    check_frame(tag, d, p);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic          pa, pb;

    rst_n       = 1'b0;
    inValid     = 1'b0;
    dataInput   = '0;
    parityInput = 1'b0;

    // Reset, no traffic.
    repeat (3) tick();
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("post_reset");

    // Directed frames.
    send("ones32", 64'hFFFF_FFFF, 1'b0);
    send("bits0_16", 64'h0001_FFFF, 1'b1);

    // Randomized frames.
    for (int n = 0; n < 3; n++) begin
      a  = {$urandom, $urandom};
      pa = 1'($urandom);
      send("random", a, pa);
    end

    // Back-to-back with inValid held: second word only on the idle cycle.
    a  = {$urandom, $urandom};
    pa = 1'($urandom);
    b  = {$urandom, $urandom};
    pb = 1'($urandom);
    dataInput   = a;
    parityInput = pa;
    inValid     = 1'b1;
    tick();
    dataInput   = b;
    parityInput = pb;
    check_frame("b2b_first", a, pa);
    tick();
    inValid = 1'b0;
    check_frame("b2b_second", b, pb);

    // Asynchronous reset during data bit 10.
    a  = {$urandom, $urandom};
    pa = 1'($urandom);
    dataInput   = a;
    parityInput = pa;
    inValid     = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (CPB + 10 * CPB + 1) tick();
    check("bit10.serial", 64'(serialOut), 64'(a[10]));
    check("bit10.busy",   64'(busy),      64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
`ifdef PARITY_SELF_CHECK_EN
    check("async_reset.parityErr", 64'(parityErr), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("reset_release");
    a  = {$urandom, $urandom};
    pa = 1'($urandom);
    send("after_reset", a, pa);

`ifdef PARITY_SELF_CHECK_EN
    // Wrong parity flags an error but the bit is still sent as given.
    send("bad_parity", 64'hAAAA_0555, 1'b1);
    a = {$urandom, $urandom};
    send("good_parity", a, exp_err(a, 1'b0) ? 1'b1 : 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
